// File: rtl/uart_rx_cfg_pkg.sv
// Shared UART receiver definitions: FSM state and parity-mode encodings
// plus small helpers used by the UART blocks.
package uart_rx_cfg_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START     = 3'd1,
    ST_DATA      = 3'd2,
    ST_PARITY    = 3'd3,
    ST_STOP      = 3'd4,
    ST_WAIT_HIGH = 3'd5
  } uart_state_e;

  typedef enum logic [1:0] {
    PAR_NONE = 2'b00,
    PAR_EVEN = 2'b01,
    PAR_ODD  = 2'b10,
    PAR_RSVD = 2'b11
  } parity_mode_e;

  // Reserved encoding behaves as "no parity".
  function automatic logic parity_on(input logic [1:0] mode);
    return (mode == PAR_EVEN) || (mode == PAR_ODD);
  endfunction

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchronizer for a single asynchronous input; reset value is
// configurable so idle-high serial lines come out of reset idle.
module uart_sync2 #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic sync_p0;
  logic sync_p1;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_p0 <= RST_VAL;
      sync_p1 <= RST_VAL;
    end else begin
      sync_p0 <= d;
      sync_p1 <= sync_p0;
    end
  end

  assign q = sync_p1;

endmodule

// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver: runtime divisor, parity and stop-bit count,
// 3-sample majority bit decisions, frame/parity error and break detection.
module uart_rx_cfg
  import uart_rx_cfg_pkg::*;
#(
  parameter int DATA_BITS = 8,
  parameter int DIV_W     = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 din,
  input  logic [DIV_W-1:0]     div,
  input  logic [1:0]           parity_mode,
  input  logic                 stop2,
  output logic [DATA_BITS-1:0] data,
  output logic                 valid,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 break_det
);

  localparam logic [3:0]       LAST_BIT = 4'(DATA_BITS - 1);
  localparam logic [DIV_W-1:0] ONE      = DIV_W'(1);

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  uart_state_e          state, state_n;
  logic                 din_s;
  logic                 din_prev;
  logic                 hist_p0, hist_p1;
  logic [DIV_W-1:0]     timer, div_q, t_target;
  logic [3:0]           bit_cnt;
  logic [DATA_BITS-1:0] shreg;
  logic                 par_en_q, odd_q, stop2_q;
  logic                 par_acc, all_low, fe_acc, brk_q;
  logic                 decide, samp, start_edge, last_stop;
  logic                 brk_now, fe_now, frame_done;

  uart_sync2 #(.RST_VAL(1'b1)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (din),
    .q   (din_s)
  );

  // Decision point and next-state logic
  always_comb begin
    t_target   = (state == ST_START) ? (div_q >> 1) : (div_q - ONE);
    decide     = (timer == t_target);
    samp       = maj3(hist_p1, hist_p0, din_s);
    start_edge = !din_s && din_prev;
    last_stop  = !stop2_q || (bit_cnt == 4'd1);
    brk_now    = (bit_cnt == 4'd0) ? (all_low & ~samp) : brk_q;
    fe_now     = fe_acc | ~samp;
    state_n    = state;
    frame_done = 1'b0;
    case (state)
      ST_IDLE:   if (start_edge) state_n = ST_START;
      ST_START:  if (decide) state_n = samp ? ST_IDLE : ST_DATA;
      ST_DATA:   if (decide && bit_cnt == LAST_BIT) state_n = par_en_q ? ST_PARITY : ST_STOP;
      ST_PARITY: if (decide) state_n = ST_STOP;
      ST_STOP: begin
        if (decide && last_stop) begin
          frame_done = 1'b1;
          state_n    = brk_now ? ST_WAIT_HIGH : ST_IDLE;
        end
      end
      ST_WAIT_HIGH: if (decide && din_s) state_n = ST_IDLE;
      default:   state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_n;
  end

  // Control: bit timer, bit counter, edge history
  always_ff @(posedge clk) begin
    if (rst) begin
      timer    <= '0;
      bit_cnt  <= '0;
      din_prev <= 1'b1;
    end else begin
      din_prev <= din_s;
      case (state)
        ST_IDLE: begin
          timer   <= '0;
          bit_cnt <= '0;
        end
        ST_WAIT_HIGH: timer <= din_s ? (timer + ONE) : '0;
        default: begin
          timer <= decide ? '0 : (timer + ONE);
          if (decide && (state == ST_DATA || state == ST_STOP))
            bit_cnt <= (state == ST_DATA && bit_cnt == LAST_BIT) ? 4'd0 : (bit_cnt + 4'd1);
        end
      endcase
    end
  end

  // Datapath: sample history, frame config latch, shift and accumulators
  always_ff @(posedge clk) begin
    hist_p0 <= din_s;
    hist_p1 <= hist_p0;
    if (state == ST_IDLE && start_edge) begin
      div_q    <= div;
      par_en_q <= parity_on(parity_mode);
      odd_q    <= (parity_mode == PAR_ODD);
      stop2_q  <= stop2;
      par_acc  <= 1'b0;
      all_low  <= 1'b1;
      fe_acc   <= 1'b0;
      brk_q    <= 1'b0;
    end else if (decide) begin
      case (state)
        ST_DATA: begin
          shreg   <= {samp, shreg[DATA_BITS-1:1]};
          par_acc <= par_acc ^ samp;
          all_low <= all_low & ~samp;
        end
        ST_PARITY: begin
          par_acc <= par_acc ^ samp;
          all_low <= all_low & ~samp;
        end
        ST_STOP: begin
          fe_acc <= fe_now;
          if (bit_cnt == 4'd0) brk_q <= brk_now;
        end
        default: ;
      endcase
    end
  end

  // Output register: flags exist only alongside the valid pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      data       <= '0;
      valid      <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      break_det  <= 1'b0;
    end else begin
      valid <= frame_done;
      if (frame_done) begin
        data       <= shreg;
        parity_err <= par_en_q & (par_acc ^ odd_q);
        frame_err  <= fe_now;
        break_det  <= brk_now;
      end else begin
        parity_err <= 1'b0;
        frame_err  <= 1'b0;
        break_det  <= 1'b0;
      end
    end
  end

endmodule
